// File: rtl/trace_pkg.sv
// Shared types for the retire trace path: the 128-bit record layout and output FSM states.
package trace_pkg;

  localparam int RECORD_WORDS = 4;
  localparam int RECORD_W     = RECORD_WORDS * 32;

  // Members are listed MSB-first, so word3 = {pad, we, rd} sits in [127:96] and pc in [31:0].
  typedef struct packed {
    logic [25:0] pad;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] instr;
    logic [31:0] pc;
  } trace_record_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } out_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is always visible on o_rdata.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 128,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rptr];

  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push && !sync_reset) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/retire_trace_packer.sv
// Packs each retired instruction into a 128-bit trace record and streams records to a
// downstream comparator through a buffered valid/ready interface.
module retire_trace_packer
  import trace_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter bit DROP_X0_WRITES = 1'b1
) (
  input  logic                        clk,
  input  logic                        sync_reset,
  input  logic                        retire_valid,
  input  logic [31:0]                 retire_pc,
  input  logic [31:0]                 retire_instr,
  input  logic                        rd_we,
  input  logic [4:0]                  rd_addr,
  input  logic [31:0]                 rd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [RECORD_W-1:0]         out_record,
  output logic [$clog2(FIFO_DEPTH):0] fill_level,
  output logic                        overflow,
  output logic [31:0]                 record_count
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  trace_record_t w_rec;
  logic          w_we;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [LW-1:0] w_level;
  logic [RECORD_W-1:0] w_head;

  out_state_t  r_state;
  logic        r_out_valid;
  logic        r_overflow;
  logic [31:0] r_count;

  assign w_we = rd_we & ~(DROP_X0_WRITES & (rd_addr == 5'd0));

  // Records with no effective write carry zero wdata/rd so the comparator sees a canonical form.
  always_comb begin
    w_rec       = '0;
    w_rec.pc    = retire_pc;
    w_rec.instr = retire_instr;
    if (w_we) begin
      w_rec.we    = 1'b1;
      w_rec.rd    = rd_addr;
      w_rec.wdata = rd_data;
    end
  end

  assign w_push = retire_valid & ~sync_reset;
  assign w_pop  = r_out_valid & out_ready & ~w_empty;

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RECORD_W)
  ) u_fifo (
    .clk        (clk),
    .sync_reset (sync_reset),
    .i_push     (w_push),
    .i_wdata    (w_rec),
    .i_pop      (w_pop),
    .o_rdata    (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (w_level)
  );

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_pop) r_count <= r_count + 32'd1;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      // Transitions look at the push of this edge so out_valid rises one cycle after the write.
      case (r_state)
        ST_IDLE: begin
          if (w_push || !w_empty) begin
            r_state     <= ST_HOLD;
            r_out_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_pop && (w_level == LW'(1)) && !w_push) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid    = r_out_valid;
  assign out_record   = w_head;
  assign fill_level   = w_level;
  assign overflow     = r_overflow;
  assign record_count = r_count;

endmodule

// File: tb/tb_retire_trace_packer.sv
// Self-checking bench for retire_trace_packer: vector table, corner sequences, random traffic vs a queue model.
module tb_retire_trace_packer;
  localparam int D  = 8;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          sync_reset;
  logic          retire_valid;
  logic [31:0]   retire_pc, retire_instr, rd_data;
  logic          rd_we;
  logic [4:0]    rd_addr;
  logic          out_valid, out_ready, overflow;
  logic [127:0]  out_record;
  logic [LW-1:0] fill_level;
  logic [31:0]   record_count;

  always #5 clk = ~clk;

  retire_trace_packer #(.FIFO_DEPTH(D), .DROP_X0_WRITES(1'b1)) dut (
    .clk(clk), .sync_reset(sync_reset), .retire_valid(retire_valid),
    .retire_pc(retire_pc), .retire_instr(retire_instr), .rd_we(rd_we),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_record(out_record), .fill_level(fill_level),
    .overflow(overflow), .record_count(record_count)
  );

  // Reference model: a bounded queue of expected records plus delivered count and sticky overflow.
  logic [127:0] q[$];
  int unsigned  m_cnt;
  bit           m_ovf;
  int           checks = 0;
  int           errors = 0;

  typedef struct {
    logic [31:0] pc, instr;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data, w2, w3;
  } vec_t;
  vec_t tbl[5];

  function automatic logic [127:0] pack(logic [31:0] pc, logic [31:0] instr,
                                        logic we, logic [4:0] rd, logic [31:0] data);
    if (we && rd != 5'd0) return {26'b0, 1'b1, rd, data, instr, pc};
    return {64'b0, instr, pc};
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
    chk("fill_level", 128'(fill_level), 128'(q.size()));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("record_count", 128'(record_count), 128'(m_cnt));
    if (q.size() != 0) chk("out_record", out_record, q[0]);
  endtask

  // One clock edge: inputs are sampled before the edge, outputs checked 1ns after it.
  task automatic step();
    bit           pop = (q.size() != 0) && out_ready;
    bit           rst = sync_reset;
    bit           rv  = retire_valid;
    logic [127:0] rec = pack(retire_pc, retire_instr, rd_we, rd_addr, rd_data);
    @(posedge clk);
    if (rst) begin
      q.delete(); m_cnt = 0; m_ovf = 0;
    end else begin
      if (pop) begin void'(q.pop_front()); m_cnt++; end
      if (rv) begin
        if (q.size() < D) q.push_back(rec);
        else m_ovf = 1;
      end
    end
    #1;
    check_model();
  endtask

  task automatic set_retire(logic v, logic [31:0] pc, logic [31:0] instr,
                            logic we, logic [4:0] rd, logic [31:0] data);
    retire_valid = v; retire_pc = pc; retire_instr = instr;
    rd_we = we; rd_addr = rd; rd_data = data;
  endtask

  task automatic do_reset();
    sync_reset = 1'b1; step(); step(); sync_reset = 1'b0;
  endtask

  initial begin
    tbl[0] = '{32'h8000_0000, 32'h0050_0093, 1'b1, 5'd1,  32'd5,          32'd5,          32'h21};
    tbl[1] = '{32'h8000_0004, 32'h0000_0013, 1'b1, 5'd0,  32'hDEAD,       32'd0,          32'h0};
    tbl[2] = '{32'h8000_0008, 32'h0000_0063, 1'b0, 5'd7,  32'h1234,       32'd0,          32'h0};
    tbl[3] = '{32'h8000_000C, 32'hFFF0_0F93, 1'b1, 5'd31, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h3F};
    tbl[4] = '{32'hFFFF_FFFC, 32'h0000_0073, 1'b1, 5'd16, 32'h0000_0000,  32'd0,          32'h30};

    sync_reset = 1'b1; out_ready = 1'b0;
    set_retire(1'b0, '0, '0, 1'b0, '0, '0);
    m_cnt = 0; m_ovf = 0;
    do_reset();
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_level", 128'(fill_level), 128'd0);
    chk("rst_count", 128'(record_count), 128'd0);
    chk("rst_ovf", 128'(overflow), 128'd0);

    // Packing table: one retire, check the record next cycle, then consume it.
    for (int i = 0; i < 5; i++) begin
      set_retire(1'b1, tbl[i].pc, tbl[i].instr, tbl[i].we, tbl[i].rd, tbl[i].data);
      step();
      set_retire(1'b0, '0, '0, 1'b0, '0, '0);
      chk("tbl_valid", 128'(out_valid), 128'd1);
      chk("tbl_word0", 128'(out_record[31:0]), 128'(tbl[i].pc));
      chk("tbl_word1", 128'(out_record[63:32]), 128'(tbl[i].instr));
      chk("tbl_word2", 128'(out_record[95:64]), 128'(tbl[i].w2));
      chk("tbl_word3", 128'(out_record[127:96]), 128'(tbl[i].w3));
      step();
      chk("tbl_stable", 128'(out_record[31:0]), 128'(tbl[i].pc));
      out_ready = 1'b1; step(); out_ready = 1'b0;
    end
    chk("tbl_count", 128'(record_count), 128'd5);

    // Overflow: nine retires into a depth-8 buffer with the consumer stalled.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      set_retire(1'b1, 32'(i), 32'h13, 1'b1, 5'd2, 32'(i * 3));
      step();
    end
    set_retire(1'b0, '0, '0, 1'b0, '0, '0);
    chk("ovf_level", 128'(fill_level), 128'd8);
    chk("ovf_flag", 128'(overflow), 128'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_order", 128'(out_record[31:0]), 128'(i));
      step();
    end
    out_ready = 1'b0;
    chk("ovf_drained", 128'(out_valid), 128'd0);
    chk("ovf_sticky", 128'(overflow), 128'd1);

    // Full buffer with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_retire(1'b1, 32'h100 + 32'(i), 32'h13, 1'b0, 5'd0, 32'd0);
      step();
    end
    out_ready = 1'b1;
    set_retire(1'b1, 32'h200, 32'h13, 1'b1, 5'd9, 32'h55);
    step();
    set_retire(1'b0, '0, '0, 1'b0, '0, '0);
    out_ready = 1'b0;
    chk("fullpp_level", 128'(fill_level), 128'd8);
    chk("fullpp_ovf", 128'(overflow), 128'd0);
    chk("fullpp_count", 128'(record_count), 128'd1);

    // Reset with records buffered and a retire arriving in the same cycle.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_retire(1'b1, 32'h300 + 32'(i), 32'h13, 1'b1, 5'd4, 32'(i));
      step();
    end
    out_ready = 1'b1; step();
    out_ready = 1'b0;
    set_retire(1'b1, 32'h400, 32'h13, 1'b1, 5'd4, 32'h77);
    step();
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
    set_retire(1'b0, '0, '0, 1'b0, '0, '0);
    chk("rst3_valid", 128'(out_valid), 128'd0);
    chk("rst3_level", 128'(fill_level), 128'd0);
    chk("rst3_count", 128'(record_count), 128'd0);
    chk("rst3_ovf", 128'(overflow), 128'd0);

    // 1000 back-to-back retires with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      set_retire(1'b1, $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom);
      step();
    end
    set_retire(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    chk("b2b_count", 128'(record_count), 128'd1000);
    chk("b2b_ovf", 128'(overflow), 128'd0);
    chk("b2b_empty", 128'(fill_level), 128'd0);

    // Random traffic, including occasional resets.
    for (int i = 0; i < 2000; i++) begin
      set_retire(1'($urandom_range(0, 99) < 60), $urandom, $urandom, 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom);
      out_ready  = ($urandom_range(0, 99) < 50);
      sync_reset = ($urandom_range(0, 299) == 0);
      step();
    end
    sync_reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/retire_trace_packer.md
RETIRE_TRACE_PACKER -- requirements
Module: retire_trace_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, record buffer depth; power of two, minimum 2.
REQ-002 SHALL have parameter DROP_X0_WRITES, default 1; when 1, a register write to x0 is recorded as no write.
REQ-003 SHALL have ports clk (in, 1, sole clock) and sync_reset (in, 1, reset); one clock, reset synchronous and active-high.
REQ-004 SHALL have port retire_valid (in, 1): one instruction retired this cycle.
REQ-005 SHALL have ports retire_pc (in, 32) and retire_instr (in, 32): PC and encoding of the retired instruction.
REQ-006 SHALL have ports rd_we (in, 1), rd_addr (in, 5) and rd_data (in, 32): register write-back of the retired instruction.
REQ-007 SHALL have port out_valid (out, 1): the head record is valid.
REQ-008 SHALL have port out_ready (in, 1): the downstream comparator accepts the head record.
REQ-009 SHALL have port out_record (out, 128): word0 = pc [31:0], word1 = instr [63:32], word2 = wdata [95:64], word3 = {26'b0, we, rd} [127:96].
REQ-010 SHALL have ports fill_level (out, $clog2(FIFO_DEPTH)+1), overflow (out, 1, sticky) and record_count (out, 32): records delivered.

Function
REQ-011 SHALL pack the record in the cycle retire_valid=1; effective we = rd_we & ~(DROP_X0_WRITES & rd_addr==0).
REQ-012 SHALL force word2 to 0 and the rd field to 0 when effective we = 0.
REQ-013 SHALL write the packed record into the FIFO at the clk edge; out_valid rises one cycle later when the FIFO was empty (latency 1).
REQ-014 SHALL present the head record first-word-fall-through; out_record is stable while out_valid=1 and out_ready=0.
REQ-015 SHALL pop on out_valid & out_ready and increment record_count by 1; record_count wraps modulo 2^32.
REQ-016 SHALL, when full with simultaneous push and pop, perform both and leave fill_level unchanged.
REQ-017 SHALL, on a push when full without a pop, drop the new record, set overflow, and leave FIFO contents unchanged.
REQ-018 SHALL, on a pop when empty, do nothing; out_valid=0, and out_record content is don't-care.
REQ-019 SHALL wrap read and write pointers modulo FIFO_DEPTH; fill_level ranges 0..FIFO_DEPTH.
REQ-020 SHALL run a two-state output FSM: IDLE (out_valid=0) -> HOLD on FIFO non-empty; HOLD -> IDLE on pop with fill_level==1 and no push; otherwise stay in HOLD.
REQ-021 SHALL keep the pipeline free of combinational paths from retire_* to out_*.

Reset
REQ-022 SHALL, when sync_reset=1 at a clk edge, clear pointers, fill_level, overflow and record_count to 0, and set the FSM to IDLE with out_valid=0.
REQ-023 SHALL ignore retire_valid while sync_reset=1; a record in flight at reset is discarded.
REQ-024 SHALL give sync_reset priority over simultaneous push and pop.

Structure
REQ-025 SHALL define trace_record_t (packed struct pc, instr, wdata, we, rd) and RECORD_WORDS=4 in shared package trace_pkg.
REQ-026 SHALL implement storage as one sub-module, trace_fifo, which is synchronous, parameterised on depth and width, and exposes full/empty/level.
REQ-027 SHALL keep packing, the FSM and the counters in retire_trace_packer.

Verification
REQ-028 Single retire pc=0x80000000, instr=0x00500093, rd_we=1, rd=1, data=5 -> next cycle out_valid=1; out_record words = 0x80000000, 0x00500093, 5, 0x21.
REQ-029 rd_we=1, rd=0, data=0xDEAD with DROP_X0_WRITES=1 -> word2=0, word3=0.
REQ-030 Hold out_ready=0 and retire 9 records with depth 8 -> fill_level=8, overflow=1; records 1-8 delivered in order after ready=1; record 9 absent.
REQ-031 With full FIFO, push and pop in the same cycle -> fill_level stays 8, no overflow, record_count +1.
REQ-032 Assert sync_reset with 3 records buffered and retire_valid=1 -> next cycle out_valid=0, fill_level=0, record_count=0, overflow=0.
REQ-033 Run 1000 back-to-back retires with out_ready=1 -> record_count=1000, no overflow, records in order.
